mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one mod-p multiplier.
REQ-002 Parameter: WIDTH, default 256, operand and result width in bits.
REQ-003 Port: i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: i_req  input  NUM_REQ  per-requester request; bit k is held high until the grant for k.
REQ-006 Port: i_a  input  NUM_REQ*WIDTH  operand A; slice k belongs to requester k.
REQ-007 Port: i_b  input  NUM_REQ*WIDTH  operand B; slice k belongs to requester k.
REQ-008 Port: o_gnt  output  NUM_REQ  one-hot grant pulse; operands sampled in the same cycle.
REQ-009 Port: o_done  output  NUM_REQ  one-hot completion pulse to the granted requester.
REQ-010 Port: o_res  output  WIDTH  product; valid only while any o_done bit is high.
REQ-011 Port: o_busy  output  1  high in every state except IDLE.
REQ-012 Port: o_mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-013 Port: o_mul_a and o_mul_b  output  WIDTH each  latched operands, stable from start until finished.
REQ-014 Port: i_mul_finished  input  1  multiplier completion pulse.
REQ-015 Port: i_mul_res  input  WIDTH  multiplier result; valid while i_mul_finished is high.

Function
REQ-016 All outputs SHALL be registered, and the FSM SHALL have four states: IDLE, ISSUE, WAIT, RETURN.
REQ-017 IDLE: when any i_req bit is sampled high, the block SHALL select the winner, latch its i_a/i_b slices, store its index, and go to ISSUE; otherwise it stays in IDLE.
REQ-018 Winner selection SHALL be round-robin: the first set i_req bit at or after pointer ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-019 ISSUE SHALL last exactly one cycle with o_gnt[idx]=1 and o_mul_start=1, then go to WAIT.
REQ-020 WAIT SHALL hold o_mul_a/o_mul_b constant; when i_mul_finished is sampled high, the block SHALL latch i_mul_res and go to RETURN.
REQ-021 RETURN SHALL last exactly one cycle with o_done[idx]=1 and o_res = latched result, set ptr = (idx+1) mod NUM_REQ, and go to IDLE.
REQ-022 Latency SHALL be: i_req sampled in IDLE at edge t -> grant and start in cycle t+1 -> done one cycle after the edge that samples i_mul_finished.
REQ-023 Back-to-back: after RETURN, at least one IDLE cycle SHALL precede the next ISSUE; the minimum issue-to-issue spacing is multiplier latency + 3 cycles.
REQ-024 Fairness: any requester holding i_req high SHALL be granted within NUM_REQ transactions.
REQ-025 i_mul_finished in IDLE, ISSUE or RETURN SHALL be ignored with no state change.
REQ-026 Changes to i_req, i_a or i_b after the grant SHALL NOT affect the transaction in flight.
REQ-027 A requester that keeps i_req high through its own RETURN SHALL be treated as a new request and competes under the updated ptr.
REQ-028 When no transaction is in flight, o_gnt, o_done and o_mul_start SHALL be 0; the operand and result registers SHALL hold their last values.

Reset
REQ-029 On i_rst_n low, the block SHALL asynchronously set state=IDLE, ptr=0, o_gnt=0, o_done=0, o_mul_start=0, o_busy=0, and o_res, o_mul_a, o_mul_b = 0.
REQ-030 A reset in the middle of a transaction SHALL abort it with no o_done; a late i_mul_finished after reset release SHALL be ignored.

Verification
REQ-031 Single request: i_req=4'b0010, a=3, b=5, multiplier model latency 10 -> o_gnt=4'b0010 one cycle after the request, o_mul_start with it, o_done=4'b0010 and o_res=15 eleven cycles later; o_busy high throughout.
REQ-032 All four requesting continuously after reset -> grant order 0,1,2,3,0; each o_done matches its grant index.
REQ-033 i_req=4'b1001 with ptr=1 -> requester 3 granted first, then 0.
REQ-034 Spurious i_mul_finished pulsed in IDLE and in ISSUE -> no o_done and no state change.
REQ-035 Reset asserted during WAIT -> all outputs 0 immediately; after release, a new i_req=4'b0001 is granted to requester 0 normally.
REQ-036 Operands changed one cycle after the grant (i_a 7->9) -> o_mul_a stays 7 and o_res uses 7.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one external mod-p multiplier among NUM_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
module mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_b,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [WIDTH-1:0]         o_res,
  output logic                     o_busy,
  output logic                     o_mul_start,
  output logic [WIDTH-1:0]         o_mul_a,
  output logic [WIDTH-1:0]         o_mul_b,
  input  logic                     i_mul_finished,
  input  logic [WIDTH-1:0]         i_mul_res
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;

  logic [WIDTH-1:0]     a_arr [NUM_REQ];
  logic [WIDTH-1:0]     b_arr [NUM_REQ];
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     ptr_next;

  // Split the flat operand buses into per-requester slices.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign a_arr[k] = i_a[k*WIDTH +: WIDTH];
    assign b_arr[k] = i_b[k*WIDTH +: WIDTH];
  end

  // Round-robin search: first set request at or after ptr, wrapping upward.
  always_comb begin
    int unsigned      sum;
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IDX_W'(sum);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves to the requester just after the one being served.
  always_comb begin
    if (32'(idx_q) == NUM_REQ - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = idx_q + IDX_W'(1);
    end
  end

  // Next-state and registered-output decode; pulses default low, data holds.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    res_d   = res_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ISSUE;
          idx_d   = win_idx;
          mul_a_d = a_arr[win_idx];
          mul_b_d = b_arr[win_idx];
          gnt_d   = NUM_REQ'(1) << win_idx;
          start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_mul_finished) begin
          state_d = S_RETURN;
          res_d   = i_mul_res;
          done_d  = NUM_REQ'(1) << idx_q;
        end
      end
      S_RETURN: begin
        state_d = S_IDLE;
        ptr_d   = ptr_next;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      res_q   <= res_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_done      = done_q;
  assign o_res       = res_q;
  assign o_busy      = busy_q;
  assign o_mul_start = start_q;
  assign o_mul_a     = mul_a_q;
  assign o_mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: table of single transactions plus hand-written corner sequences,
// with a multiplier model and grant/done scoreboards.
module tb_mul_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 256;
  localparam int unsigned LAT = 10;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_a, i_b;
  logic [N-1:0]   o_gnt, o_done;
  logic [W-1:0]   o_res, o_mul_a, o_mul_b;
  logic           o_busy, o_mul_start;
  logic           i_mul_finished;
  logic [W-1:0]   i_mul_res;

  logic [W-1:0]   a_s [N];
  logic [W-1:0]   b_s [N];
  logic           fin_m = 1'b0;
  logic           fin_spur;
  logic [W-1:0]   mres = '0;
  int             cnt = 0;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int gnt_cyc = 0;

  typedef struct {
    logic [N-1:0] d;
    logic [W-1:0] r;
  } dexp_t;

  typedef struct {
    logic [N-1:0] req;
    int unsigned  idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  logic [N-1:0] gq [$];
  dexp_t        dq [$];
  vec_t         tbl [8];

  assign i_a = {a_s[3], a_s[2], a_s[1], a_s[0]};
  assign i_b = {b_s[3], b_s[2], b_s[1], b_s[0]};
  assign i_mul_finished = fin_m | fin_spur;
  assign i_mul_res = mres;

  mul_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_a(i_a), .i_b(i_b),
    .o_gnt(o_gnt), .o_done(o_done), .o_res(o_res), .o_busy(o_busy),
    .o_mul_start(o_mul_start), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b),
    .i_mul_finished(i_mul_finished), .i_mul_res(i_mul_res)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc = cyc + 1;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nmis = nmis + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic fail(input string name);
    nvec = nvec + 1;
    nmis = nmis + 1;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Multiplier model: finished pulses LAT cycles after the start cycle.
  always @(negedge i_clk) begin
    if (o_mul_start) begin
      cnt   = LAT;
      fin_m = 1'b0;
    end else if (cnt > 0) begin
      cnt   = cnt - 1;
      fin_m = (cnt == 0);
      if (cnt == 0) mres = o_mul_a * o_mul_b;
    end else begin
      fin_m = 1'b0;
    end
  end

  // Scoreboard monitor for grant and completion pulses.
  always @(negedge i_clk) begin
    logic [N-1:0] eg;
    dexp_t        ed;
    if (i_rst_n) begin
      if (o_gnt != '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", W'(o_gnt), '0);
        end else begin
          eg = gq.pop_front();
          chk("gnt", W'(o_gnt), W'(eg));
          chk("start_with_gnt", W'(o_mul_start), W'(1'b1));
          chk("busy_at_gnt", W'(o_busy), W'(1'b1));
        end
        gnt_cyc = cyc;
      end else if (o_mul_start) begin
        chk("start_without_gnt", W'(o_mul_start), '0);
      end
      if (o_done != '0) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", W'(o_done), '0);
        end else begin
          ed = dq.pop_front();
          chk("done", W'(o_done), W'(ed.d));
          chk("res", o_res, ed.r);
          chk("latency", W'(cyc - gnt_cyc), W'(LAT + 1));
          chk("busy_at_done", W'(o_busy), W'(1'b1));
        end
      end
    end
  end

  task automatic wait_gnt(input string name);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_gnt == '0 && n < 200);
    if (o_gnt == '0) fail(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while ((o_busy || gq.size() != 0 || dq.size() != 0) && n < 200);
    if (o_busy || gq.size() != 0 || dq.size() != 0) begin
      fail(name);
      gq.delete();
      dq.delete();
    end
  endtask

  task automatic expect_txn(input int unsigned idx, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    p = a * b;
    gq.push_back(N'(1) << idx);
    dq.push_back('{d: N'(1) << idx, r: p});
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_gnt"}, W'(o_gnt), '0);
    chk({tag, "_done"}, W'(o_done), '0);
    chk({tag, "_busy"}, W'(o_busy), '0);
    chk({tag, "_start"}, W'(o_mul_start), '0);
    chk({tag, "_res"}, o_res, '0);
    chk({tag, "_mul_a"}, o_mul_a, '0);
    chk({tag, "_mul_b"}, o_mul_b, '0);
  endtask

  initial begin
    int ng;
    int n;
    // Pointer evolves 0 ->2 ->3 ->1 ->0 ->1 ->3 ->0 ->2 across the table.
    tbl[0] = '{4'b0010, 1, W'(3),  W'(5)};
    tbl[1] = '{4'b1111, 2, W'(11), W'(13)};
    tbl[2] = '{4'b0011, 0, W'(17), W'(19)};
    tbl[3] = '{4'b1001, 3, W'(23), W'(29)};
    tbl[4] = '{4'b1001, 0, W'(31), W'(37)};
    tbl[5] = '{4'b0100, 2, {W{1'b1}}, W'(2)};
    tbl[6] = '{4'b1000, 3, W'(64'hFFFF_FFFF_FFFF_FFFF), W'(64'hFFFF_FFFF_FFFF_FFFF)};
    tbl[7] = '{4'b0110, 1, W'(41), W'(43)};

    i_rst_n  = 1'b0;
    i_req    = '0;
    fin_spur = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end
    repeat (3) @(negedge i_clk);
    check_zero_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Table of single transactions; non-winning slices carry random junk.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < N; k++) begin
        a_s[k] = W'($urandom);
        b_s[k] = W'($urandom);
      end
      a_s[tbl[v].idx] = tbl[v].a;
      b_s[tbl[v].idx] = tbl[v].b;
      expect_txn(tbl[v].idx, tbl[v].a, tbl[v].b);
      i_req = tbl[v].req;
      wait_gnt("table_gnt_timeout");
      i_req = '0;
      wait_idle("table_idle_timeout");
    end

    // Operand change after grant must not disturb the transaction (ptr=2 -> only req 0).
    a_s[0] = W'(7);
    b_s[0] = W'(6);
    expect_txn(0, W'(7), W'(6));
    i_req = 4'b0001;
    wait_gnt("opchg_gnt_timeout");
    i_req  = '0;
    a_s[0] = W'(9);
    repeat (3) @(negedge i_clk);
    chk("mul_a_held", o_mul_a, W'(7));
    wait_idle("opchg_idle_timeout");

    // Spurious finished in IDLE: nothing happens.
    fin_spur = 1'b1;
    @(negedge i_clk);
    fin_spur = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      chk("spur_idle_busy", W'(o_busy), '0);
    end

    // Spurious finished in ISSUE: ignored, normal latency follows (ptr=1 -> req 2).
    a_s[2] = W'(12);
    b_s[2] = W'(12);
    expect_txn(2, W'(12), W'(12));
    i_req = 4'b0100;
    wait_gnt("spur_gnt_timeout");
    fin_spur = 1'b1;
    i_req    = '0;
    @(negedge i_clk);
    fin_spur = 1'b0;
    chk("spur_issue_busy", W'(o_busy), W'(1'b1));
    chk("spur_issue_done", W'(o_done), '0);
    wait_idle("spur_idle_timeout");

    // Reset during WAIT aborts with no done (ptr=3 -> req 1 wins).
    a_s[1] = W'(5);
    b_s[1] = W'(5);
    gq.push_back(4'b0010);
    i_req = 4'b0010;
    wait_gnt("rst_gnt_timeout");
    i_req = '0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_wait");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (12) @(negedge i_clk);
    chk("late_fin_busy", W'(o_busy), '0);
    chk("late_fin_done", W'(o_done), '0);
    a_s[0] = W'(8);
    b_s[0] = W'(9);
    expect_txn(0, W'(8), W'(9));
    i_req = 4'b0001;
    wait_gnt("post_rst_gnt_timeout");
    i_req = '0;
    wait_idle("post_rst_idle_timeout");

    // Fresh reset, all four requesting continuously: order 0,1,2,3,0.
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      a_s[k] = W'(k + 2);
      b_s[k] = W'(k + 11);
    end
    for (int j = 0; j < 5; j++) begin
      expect_txn(j % N, W'((j % N) + 2), W'((j % N) + 11));
    end
    i_req = 4'b1111;
    ng = 0;
    n  = 0;
    while (ng < 5 && n < 400) begin
      @(negedge i_clk);
      n++;
      if (o_gnt != '0) begin
        ng++;
        if (ng == 5) i_req = '0;
      end
    end
    i_req = '0;
    if (ng < 5) fail("rr_gnt_timeout");
    wait_idle("rr_idle_timeout");
    repeat (3) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
